// File: rtl/ws2812_pkg.sv
// Shared ws2812 definitions: wire byte order, write-state encodings and a
// width helper used by both the frame buffer and the strip driver.
package ws2812_pkg;

    // Byte position within one LED on the wire (G first).
    localparam int unsigned COLOR_G = 0;
    localparam int unsigned COLOR_R = 1;
    localparam int unsigned COLOR_B = 2;

    // Write FSM: the first three states equal the colour index they expect.
    localparam logic [1:0] W_G    = 2'(COLOR_G);
    localparam logic [1:0] W_R    = 2'(COLOR_R);
    localparam logic [1:0] W_B    = 2'(COLOR_B);
    localparam logic [1:0] W_FULL = 2'd3;

    // Bits needed to index n items, never less than 1.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel RAM holding both banks. Address MSB selects the bank.
// Unreset with a registered read so it maps onto block RAM.
module ws2812_pixel_ram #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [23:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W:0]   raddr,
    output logic [23:0]       rdata
);

    // Sized to the full {bank, index} space so non-power-of-2 chains stay in range.
    localparam int unsigned DEPTH = 2 << ADDR_W;

    logic [23:0] mem [DEPTH];
    logic [23:0] rdata_q;

    // Write port and enabled registered read port; read data holds when idle.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ws2812_frame_buffer.sv
// Double-buffered frame store feeding the ws2812 driver. Bytes arrive as
// G,R,B per LED into the back bank; banks swap at the driver's address-0
// request once a full frame is in, so the strip never shows a torn frame.
module ws2812_frame_buffer
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 64,
    parameter int unsigned ADDR_W   = log2(NUM_LEDS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_data,
    input  logic              wr_sof,
    output logic              frame_done,
    input  logic              data_request,
    input  logic [ADDR_W-1:0] address,
    output logic [7:0]        red_out,
    output logic [7:0]        green_out,
    output logic [7:0]        blue_out,
    output logic              front_bank,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_LED  = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]   LED_COUNT = (ADDR_W + 1)'(NUM_LEDS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        g_hold_q, g_hold_d;
    logic [7:0]        r_hold_q, r_hold_d;
    logic              swap_pending_q, swap_pending_d;
    logic              front_bank_q, front_bank_d;
    logic              front_valid_q, front_valid_d;
    logic              overrun_q, overrun_d;
    logic              rd_blank_q, rd_blank_d;

    logic              accept;
    logic              swap;
    logic              ram_we;
    logic [23:0]       rd_word;

    assign wr_ready = (state_q != W_FULL);
    assign accept   = wr_valid && wr_ready;
    assign swap     = data_request && (address == '0) && swap_pending_q;

    // Next-state for the write FSM, bank swap and read blanking.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        g_hold_d       = g_hold_q;
        r_hold_d       = r_hold_q;
        swap_pending_d = swap_pending_q;
        front_bank_d   = front_bank_q;
        front_valid_d  = front_valid_q;
        overrun_d      = overrun_q;
        rd_blank_d     = rd_blank_q;
        ram_we         = 1'b0;
        frame_done     = 1'b0;

        // Pending only while W_FULL stalls writes, so this never races a write.
        if (swap) begin
            front_bank_d   = ~front_bank_q;
            swap_pending_d = 1'b0;
            front_valid_d  = 1'b1;
            state_d        = W_G;
            ptr_d          = '0;
        end

        if (accept) begin
            if (wr_sof) begin
                g_hold_d = wr_data;
                ptr_d    = '0;
                state_d  = W_R;
                if (!((state_q == W_G) && (ptr_q == '0))) overrun_d = 1'b1;
            end else begin
                unique case (state_q)
                    W_G: begin
                        g_hold_d = wr_data;
                        state_d  = W_R;
                    end
                    W_R: begin
                        r_hold_d = wr_data;
                        state_d  = W_B;
                    end
                    W_B: begin
                        ram_we = 1'b1;
                        if (ptr_q == LAST_LED) begin
                            state_d        = W_FULL;
                            frame_done     = 1'b1;
                            swap_pending_d = 1'b1;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;
                            state_d = W_G;
                        end
                    end
                    W_FULL: ;
                endcase
            end
        end

        // Front validity seen by this read includes a swap in the same cycle.
        if (data_request) begin
            rd_blank_d = !(front_valid_q || swap) || ({1'b0, address} >= LED_COUNT);
        end
    end

    // Control state; RAM contents are deliberately left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= W_G;
            ptr_q          <= '0;
            g_hold_q       <= 8'h00;
            r_hold_q       <= 8'h00;
            swap_pending_q <= 1'b0;
            front_bank_q   <= 1'b0;
            front_valid_q  <= 1'b0;
            overrun_q      <= 1'b0;
            rd_blank_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            g_hold_q       <= g_hold_d;
            r_hold_q       <= r_hold_d;
            swap_pending_q <= swap_pending_d;
            front_bank_q   <= front_bank_d;
            front_valid_q  <= front_valid_d;
            overrun_q      <= overrun_d;
            rd_blank_q     <= rd_blank_d;
        end
    end

    ws2812_pixel_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({~front_bank_q, ptr_q}),
        .wdata ({r_hold_q, g_hold_q, wr_data}),
        .re    (data_request),
        .raddr ({front_bank_q ^ swap, address}),
        .rdata (rd_word)
    );

    // Blank flag gates the unreset RAM output, giving 0 on reset and before the first frame.
    assign red_out    = rd_blank_q ? 8'h00 : rd_word[23:16];
    assign green_out  = rd_blank_q ? 8'h00 : rd_word[15:8];
    assign blue_out   = rd_blank_q ? 8'h00 : rd_word[7:0];
    assign front_bank = front_bank_q;
    assign overrun    = overrun_q;

endmodule
